// File: rtl/fwd_track_unit_if.sv
// rtl/fwd_track_unit_if.sv - decode-side issue, result and read-port bundle for fwd_track_unit
interface fwd_track_unit_if #(
  parameter int WIDTH = 32,
  parameter int AW    = 5,
  parameter int DEPTH = 3,
  parameter int NRD   = 2,
  parameter int TW    = 2
);
  logic                   iss_valid;
  logic [AW-1:0]          iss_dst;
  logic [TW-1:0]          iss_tnew;
  logic                   flush;
  logic [DEPTH-1:0]       res_wr;
  logic [DEPTH*WIDTH-1:0] res_data;
  logic [NRD*AW-1:0]      rd_addr;
  logic [NRD*TW-1:0]      rd_tuse;
  logic [NRD*WIDTH-1:0]   rd_rfdata;
  logic [NRD*WIDTH-1:0]   rd_data;
  logic [NRD-1:0]         rd_pend;
  logic                   stall;

  modport master (
    output iss_valid, iss_dst, iss_tnew, flush, res_wr, res_data,
           rd_addr, rd_tuse, rd_rfdata,
    input  rd_data, rd_pend, stall
  );

  modport slave (
    input  iss_valid, iss_dst, iss_tnew, flush, res_wr, res_data,
           rd_addr, rd_tuse, rd_rfdata,
    output rd_data, rd_pend, stall
  );
endinterface

// File: rtl/fwd_track_unit.sv
// rtl/fwd_track_unit.sv - in-flight write tracker resolving forwarded operands and decode stalls
module fwd_track_unit #(
  parameter int WIDTH = 32,
  parameter int AW    = 5,
  parameter int DEPTH = 3,
  parameter int NRD   = 2,
  parameter int TW    = 2
) (
  input  logic            clk,
  input  logic            reset,
  fwd_track_unit_if.slave bus
);

  logic [DEPTH-1:0]            valid_q, valid_d;
  logic [DEPTH-1:0][AW-1:0]    dst_q,   dst_d;
  logic [DEPTH-1:0][TW-1:0]    tnew_q,  tnew_d;
  logic [DEPTH-1:0][WIDTH-1:0] data_q,  data_d;
  logic [DEPTH-1:0]            rdy_q,   rdy_d;

  logic [DEPTH-1:0]            rdy_eff;
  logic [DEPTH-1:0][WIDTH-1:0] data_eff;

  logic [NRD*WIDTH-1:0] rd_data_c;
  logic [NRD-1:0]       rd_pend_c;
  logic [NRD-1:0]       stall_req;
  logic                 stall_c;

  // A result arriving this cycle is visible to readers and to the shift alike.
  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      rdy_eff[k]  = rdy_q[k];
      data_eff[k] = data_q[k];
      if (bus.res_wr[k] && valid_q[k]) begin
        rdy_eff[k]  = 1'b1;
        data_eff[k] = bus.res_data[k*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin : port_resolve
    logic [AW-1:0]    addr;
    logic [TW-1:0]    tuse;
    logic             m_found;
    logic             m_rdy;
    logic [WIDTH-1:0] m_data;
    logic [TW-1:0]    m_tnew;
    rd_data_c = bus.rd_rfdata;
    rd_pend_c = '0;
    stall_req = '0;
    for (int i = 0; i < NRD; i++) begin
      addr    = bus.rd_addr[i*AW +: AW];
      tuse    = bus.rd_tuse[i*TW +: TW];
      m_found = 1'b0;
      m_rdy   = 1'b0;
      m_data  = '0;
      m_tnew  = '0;
      // Walk oldest to youngest so the youngest match is the one left standing.
      for (int k = DEPTH-1; k >= 0; k--) begin
        if (valid_q[k] && (dst_q[k] == addr) && (addr != '0)) begin
          m_found = 1'b1;
          m_rdy   = rdy_eff[k];
          m_data  = data_eff[k];
          m_tnew  = tnew_q[k];
        end
      end
      if (m_found) begin
        if (m_rdy) begin
          rd_data_c[i*WIDTH +: WIDTH] = m_data;
        end else if (m_tnew <= tuse) begin
          rd_pend_c[i] = 1'b1;
        end else begin
          stall_req[i] = 1'b1;
        end
      end
    end
    stall_c = |stall_req;
  end

  always_comb begin
    valid_d[0] = 1'b0;
    dst_d[0]   = '0;
    tnew_d[0]  = '0;
    data_d[0]  = '0;
    rdy_d[0]   = 1'b0;
    if (!stall_c && !bus.flush) begin
      valid_d[0] = bus.iss_valid && (bus.iss_dst != '0);
      dst_d[0]   = bus.iss_dst;
      tnew_d[0]  = bus.iss_tnew;
      rdy_d[0]   = (bus.iss_tnew == '0);
    end
    for (int k = 0; k < DEPTH-1; k++) begin
      valid_d[k+1] = valid_q[k];
      dst_d[k+1]   = dst_q[k];
      tnew_d[k+1]  = (tnew_q[k] == '0) ? '0 : tnew_q[k] - TW'(1);
      data_d[k+1]  = data_eff[k];
      rdy_d[k+1]   = rdy_eff[k];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      dst_q   <= '0;
      tnew_q  <= '0;
      data_q  <= '0;
      rdy_q   <= '0;
    end else begin
      valid_q <= valid_d;
      dst_q   <= dst_d;
      tnew_q  <= tnew_d;
      data_q  <= data_d;
      rdy_q   <= rdy_d;
    end
  end

  assign bus.rd_data = rd_data_c;
  assign bus.rd_pend = rd_pend_c;
  assign bus.stall   = stall_c;

endmodule

// File: tb/tb_fwd_track_unit.sv
// tb/tb_fwd_track_unit.sv - directed scoreboard bench for fwd_track_unit
module tb_fwd_track_unit;
  localparam int WIDTH = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 3;
  localparam int NRD   = 2;
  localparam int TW    = 2;

  localparam int S_D0 = 0, S_D1 = 1, S_PEND = 2, S_STALL = 3;

  logic clk;
  logic reset;

  fwd_track_unit_if #(.WIDTH(WIDTH), .AW(AW), .DEPTH(DEPTH), .NRD(NRD), .TW(TW)) bus ();

  fwd_track_unit #(.WIDTH(WIDTH), .AW(AW), .DEPTH(DEPTH), .NRD(NRD), .TW(TW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   vectors;
  int   miscompares;

  task automatic clr();
    bus.iss_valid = 1'b0;
    bus.iss_dst   = '0;
    bus.iss_tnew  = '0;
    bus.flush     = 1'b0;
    bus.res_wr    = '0;
    bus.res_data  = '0;
    bus.rd_addr   = '0;
    bus.rd_tuse   = '0;
    bus.rd_rfdata = {32'hF00D_0001, 32'hF00D_0000};
  endtask

  task automatic iss(input logic [AW-1:0] dst, input logic [TW-1:0] tnew);
    bus.iss_valid = 1'b1;
    bus.iss_dst   = dst;
    bus.iss_tnew  = tnew;
  endtask

  task automatic rd(input int p, input logic [AW-1:0] a, input logic [TW-1:0] tu,
                    input logic [WIDTH-1:0] rf);
    bus.rd_addr[p*AW +: AW]          = a;
    bus.rd_tuse[p*TW +: TW]          = tu;
    bus.rd_rfdata[p*WIDTH +: WIDTH]  = rf;
  endtask

  task automatic res(input int k, input logic [WIDTH-1:0] d);
    bus.res_wr[k]                   = 1'b1;
    bus.res_data[k*WIDTH +: WIDTH]  = d;
  endtask

  task automatic expect_v(input string tag, input int sel, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.val = val;
    sb.push_back(e);
  endtask

  // Compare at the falling edge, then advance to just past the next rising edge.
  task automatic step();
    exp_t        e;
    logic [31:0] obs;
    @(negedge clk);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.sel)
        S_D0:    obs = bus.rd_data[31:0];
        S_D1:    obs = bus.rd_data[63:32];
        S_PEND:  obs = {30'b0, bus.rd_pend};
        default: obs = {31'b0, bus.stall};
      endcase
      vectors++;
      assert (obs === e.val) else begin
        miscompares++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int n = 0; n < DEPTH + 1; n++) begin
      clr();
      step();
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    clr();
    reset = 1'b1;
    iss(5'd5, 2'd1);
    @(posedge clk);
    @(posedge clk);
    #1;

    // reset state
    reset = 1'b0;
    clr();
    rd(0, 5'd5, 2'd0, 32'h11);
    expect_v("rst_data", S_D0, 32'h11);
    expect_v("rst_stall", S_STALL, 32'd0);
    expect_v("rst_pend", S_PEND, 32'd0);
    step();

    // ALU producer
    clr();
    iss(5'd8, 2'd1);
    expect_v("alu_issue_stall", S_STALL, 32'd0);
    step();
    clr();
    res(0, 32'hDEADBEEF);
    rd(0, 5'd8, 2'd0, 32'h55);
    expect_v("alu_s0_data", S_D0, 32'hDEADBEEF);
    expect_v("alu_s0_stall", S_STALL, 32'd0);
    expect_v("alu_s0_pend", S_PEND, 32'd0);
    step();
    clr();
    rd(0, 5'd8, 2'd0, 32'h55);
    expect_v("alu_s1_data", S_D0, 32'hDEADBEEF);
    step();
    clr();
    rd(0, 5'd8, 2'd0, 32'h55);
    expect_v("alu_s2_data", S_D0, 32'hDEADBEEF);
    step();
    clr();
    rd(0, 5'd8, 2'd0, 32'h55);
    expect_v("alu_dropped", S_D0, 32'h55);
    step();
    drain();

    // load-use
    clr();
    iss(5'd9, 2'd2);
    step();
    clr();
    rd(0, 5'd9, 2'd0, 32'h66);
    expect_v("lu_stall", S_STALL, 32'd1);
    expect_v("lu_stall_pend", S_PEND, 32'd0);
    step();
    clr();
    rd(0, 5'd9, 2'd0, 32'h66);
    res(1, 32'h1234);
    expect_v("lu_fwd_data", S_D0, 32'h1234);
    expect_v("lu_fwd_stall", S_STALL, 32'd0);
    step();
    clr();
    rd(0, 5'd9, 2'd0, 32'h66);
    expect_v("lu_s2_data", S_D0, 32'h1234);
    step();
    drain();

    // youngest match priority and register 0
    clr();
    iss(5'd3, 2'd1);
    step();
    clr();
    res(0, 32'hBBBB);
    iss(5'd0, 2'd0);
    rd(1, 5'd0, 2'd0, 32'h0);
    expect_v("r0_read", S_D1, 32'h0);
    step();
    clr();
    iss(5'd3, 2'd0);
    rd(0, 5'd3, 2'd0, 32'h77);
    rd(1, 5'd0, 2'd0, 32'h0);
    expect_v("old_only", S_D0, 32'hBBBB);
    expect_v("r0_no_entry", S_D1, 32'h0);
    expect_v("r0_stall", S_STALL, 32'd0);
    step();
    clr();
    res(0, 32'hAAAA);
    rd(0, 5'd3, 2'd0, 32'h77);
    rd(1, 5'd0, 2'd0, 32'h0);
    expect_v("prio_young", S_D0, 32'hAAAA);
    expect_v("prio_r0", S_D1, 32'h0);
    expect_v("prio_stall", S_STALL, 32'd0);
    step();
    clr();
    rd(0, 5'd3, 2'd0, 32'h77);
    expect_v("prio_after", S_D0, 32'hAAAA);
    step();
    drain();

    // pending path
    clr();
    iss(5'd4, 2'd2);
    step();
    clr();
    rd(1, 5'd4, 2'd2, 32'h99);
    expect_v("pend_s0", S_PEND, 32'd2);
    expect_v("pend_s0_stall", S_STALL, 32'd0);
    step();
    clr();
    rd(1, 5'd4, 2'd1, 32'h99);
    rd(0, 5'd4, 2'd0, 32'h98);
    expect_v("pend_s1", S_PEND, 32'd2);
    expect_v("pend_s1_stall", S_STALL, 32'd1);
    step();
    clr();
    rd(1, 5'd4, 2'd0, 32'h99);
    rd(0, 5'd4, 2'd0, 32'h98);
    expect_v("pend_s2_both", S_PEND, 32'd3);
    expect_v("pend_s2_stall", S_STALL, 32'd0);
    step();
    drain();

    // flush with stall, flush alone, reset mid-flight
    clr();
    iss(5'd9, 2'd3);
    step();
    clr();
    iss(5'd10, 2'd1);
    bus.flush = 1'b1;
    rd(0, 5'd9, 2'd0, 32'h66);
    expect_v("fs_stall", S_STALL, 32'd1);
    step();
    clr();
    rd(0, 5'd9, 2'd0, 32'h66);
    rd(1, 5'd10, 2'd3, 32'hAB);
    expect_v("fs_bubble", S_D1, 32'hAB);
    expect_v("fs_bubble_pend", S_PEND, 32'd0);
    expect_v("fs_still_stall", S_STALL, 32'd1);
    step();
    clr();
    iss(5'd11, 2'd0);
    bus.flush = 1'b1;
    rd(0, 5'd9, 2'd3, 32'h66);
    expect_v("fl_pend", S_PEND, 32'd1);
    expect_v("fl_nostall", S_STALL, 32'd0);
    step();
    clr();
    rd(1, 5'd11, 2'd0, 32'hCD);
    expect_v("fl_bubble", S_D1, 32'hCD);
    step();
    clr();
    iss(5'd12, 2'd1);
    step();
    clr();
    iss(5'd13, 2'd2);
    step();
    clr();
    reset = 1'b1;
    iss(5'd14, 2'd0);
    res(0, 32'h5555);
    @(posedge clk);
    #1;
    reset = 1'b0;
    clr();
    res(0, 32'hA0A0);
    res(1, 32'hA1A1);
    res(2, 32'hA2A2);
    rd(0, 5'd12, 2'd0, 32'h1);
    rd(1, 5'd13, 2'd0, 32'h2);
    expect_v("rst2_d0", S_D0, 32'h1);
    expect_v("rst2_d1", S_D1, 32'h2);
    expect_v("rst2_pend", S_PEND, 32'd0);
    expect_v("rst2_stall", S_STALL, 32'd0);
    step();
    clr();
    rd(0, 5'd14, 2'd0, 32'h3);
    expect_v("rst2_no_load", S_D0, 32'h3);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
